// File: rtl/cpu_pkg.sv
// Shared CPU constants: reset/handler PCs, instruction-memory window,
// CP0 ExcCode values, and the IF/ID register payload type.
package cpu_pkg;

  localparam int PC_W  = 32;
  localparam int EXC_W = 5;

  localparam logic [PC_W-1:0] PC_DEFAULT  = 32'h0000_3000;
  localparam logic [PC_W-1:0] EXC_HANDLER = 32'h0000_4180;
  localparam logic [PC_W-1:0] IM_BASE     = 32'h0000_3000;
  localparam logic [PC_W-1:0] IM_LIMIT    = 32'h0000_6FFF;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  // Everything decode sees from the IF/ID boundary
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [31:0]      instr;
    logic [EXC_W-1:0] exccode;
    logic             bd;
    logic             valid;
  } id_regs_t;

  localparam id_regs_t ID_RESET = '{
    pc:      PC_DEFAULT,
    instr:   32'h0,
    exccode: EXC_NONE,
    bd:      1'b0,
    valid:   1'b0
  };

endpackage

// File: rtl/if_id_reg_if.sv
// IF/ID boundary bundle: hazard controls, fetch-side inputs, decode-side outputs.
// Optional IFID_STAT_EN adds the two statistics counters.
interface if_id_reg_if;
  import cpu_pkg::*;

  logic             stall;
  logic             flush_exc;
  logic             eret_flush;
  logic [PC_W-1:0]  if_pc;
  logic [31:0]      if_instr;
  logic             if_bd;
  logic [PC_W-1:0]  id_pc;
  logic [31:0]      id_instr;
  logic [EXC_W-1:0] id_exccode;
  logic             id_bd;
  logic             id_valid;
`ifdef IFID_STAT_EN
  logic [31:0]      stat_fetched;
  logic [31:0]      stat_stalls;
`endif

  // Pipeline-register view
  modport slave (
    input  stall, flush_exc, eret_flush, if_pc, if_instr, if_bd,
`ifdef IFID_STAT_EN
    output stat_fetched, stat_stalls,
`endif
    output id_pc, id_instr, id_exccode, id_bd, id_valid
  );

  // Fetch/hazard/decode view
  modport master (
    output stall, flush_exc, eret_flush, if_pc, if_instr, if_bd,
`ifdef IFID_STAT_EN
    input  stat_fetched, stat_stalls,
`endif
    input  id_pc, id_instr, id_exccode, id_bd, id_valid
  );
endinterface

// File: rtl/if_id_reg_fetch_exc_check.sv
// Address-error check: alignment plus an inclusive legal window, unsigned.
// Reused for M-stage load/store checks by overriding the window, alignment
// mask and the code to report (AdEL/AdES).
module fetch_exc_check
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]  BASE       = IM_BASE,
  parameter logic [PC_W-1:0]  LIMIT      = IM_LIMIT,
  parameter logic [1:0]       ALIGN_MASK = 2'b11,
  parameter logic [EXC_W-1:0] CODE       = EXC_ADEL
) (
  input  logic [PC_W-1:0]  addr,
  output logic             err,
  output logic [EXC_W-1:0] exccode
);

  // Misaligned or outside [BASE, LIMIT] raises the configured code
  always_comb begin
    err     = (|(addr[1:0] & ALIGN_MASK)) | (addr < BASE) | (addr > LIMIT);
    exccode = err ? CODE : EXC_NONE;
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with AdEL tagging, stall and two flush sources.
// Edge priority: reset > flush_exc > stall > eret_flush > load.
// Optional macro IFID_STAT_EN: stat_fetched / stat_stalls counters.
module if_id_reg
  import cpu_pkg::PC_W, cpu_pkg::EXC_W, cpu_pkg::EXC_NONE,
         cpu_pkg::id_regs_t, cpu_pkg::ID_RESET;
#(
  parameter logic [PC_W-1:0] IM_BASE    = cpu_pkg::IM_BASE,
  parameter logic [PC_W-1:0] IM_LIMIT   = cpu_pkg::IM_LIMIT,
  parameter logic [PC_W-1:0] HANDLER_PC = cpu_pkg::EXC_HANDLER
) (
  input logic         clk,
  input logic         reset,
  if_id_reg_if.slave  bus
);

  // Initialiser doubles as the power-up state so sim starts out of reset values
  id_regs_t         q = ID_RESET;
  id_regs_t         d;
  logic             adel;
  logic [EXC_W-1:0] adel_code;
  logic             load_en;

  fetch_exc_check #(
    .BASE  (IM_BASE),
    .LIMIT (IM_LIMIT)
  ) u_chk (
    .addr    (bus.if_pc),
    .err     (adel),
    .exccode (adel_code)
  );

  assign load_en = ~bus.flush_exc & ~bus.stall & ~bus.eret_flush;

  // Next-state select; eret squash drops a wrong-path AdEL on the floor
  always_comb begin
    d = q;
    if (bus.flush_exc)
      d = '{pc: HANDLER_PC, instr: 32'h0, exccode: EXC_NONE, bd: 1'b0, valid: 1'b0};
    else if (bus.stall)
      d = q;
    else if (bus.eret_flush)
      d = '{pc: bus.if_pc, instr: 32'h0, exccode: EXC_NONE, bd: 1'b0, valid: 1'b0};
    else if (adel)
      d = '{pc: bus.if_pc, instr: 32'h0, exccode: adel_code, bd: bus.if_bd, valid: 1'b1};
    else
      d = '{pc: bus.if_pc, instr: bus.if_instr, exccode: EXC_NONE, bd: bus.if_bd, valid: 1'b1};
  end

  // Register update, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) q <= ID_RESET;
    else       q <= d;
  end

  assign bus.id_pc      = q.pc;
  assign bus.id_instr   = q.instr;
  assign bus.id_exccode = q.exccode;
  assign bus.id_bd      = q.bd;
  assign bus.id_valid   = q.valid;

`ifdef IFID_STAT_EN
  logic [31:0] fetch_cnt = '0;
  logic [31:0] stall_cnt = '0;

  // Free-running wrap counters of good loads and effective stall edges
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (load_en & ~adel)               fetch_cnt <= fetch_cnt + 32'd1;
      if (bus.stall & ~bus.flush_exc)    stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stat_fetched = fetch_cnt;
  assign bus.stat_stalls  = stall_cnt;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule
